// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//
// AHB slave that fronts a word-organised on-chip SRAM. It implements the
// standard two-stage pipeline: the address phase is accepted on a rising
// edge, and the data phase follows. Each beat is handled on its own, so
// single and burst transfers are treated the same way. The slave supports
// byte, halfword and word transfers, a fixed number of wait states on every
// OKAY data phase, and the two-cycle ERROR response.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two)
//   WAIT_STATES  HREADYOUT-low cycles inserted in every OKAY data phase (0..15)
//
// Optional feature
//   AHB_SRAM_RANGE_ERR_EN  when defined, any address whose bits above the
//                          array range are non-zero gets an ERROR response.
//                          When undefined, those bits are ignored and the
//                          address wraps modulo DEPTH*4 bytes.
//
// Ports
//   HCLK       in   1   clock, all state changes on the rising edge
//   HRESET     in   1   synchronous reset, active-high
//   HSEL       in   1   slave select from the address decoder
//   HADDR      in   32  byte address
//   HTRANS     in   2   IDLE/BUSY/NONSEQ/SEQ
//   HWRITE     in   1   1 = write, 0 = read
//   HSIZE      in   3   byte/half/word; any other value is illegal
//   HBURST     in   3   burst type (not used; every beat is independent)
//   HWDATA     in   32  write data, valid in the data phase
//   HREADY     in   1   bus-level ready
//   HREADYOUT  out  1   this slave's ready (registered)
//   HRESP      out  2   OKAY=00 / ERROR=01 (registered)
//   HRDATA     out  32  read data, taken directly from the array
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  // Reload value for the wait-state counter. The counter counts down to zero
  // inside WAIT, which yields exactly WAIT_STATES low cycles.
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t          state_r;
  logic [3:0]      wait_cnt_r;
  logic [AW-1:0]   dp_index_r;
  logic [3:0]      dp_lanes_r;
  logic            dp_write_r;
  logic            hreadyout_r;
  logic [1:0]      hresp_r;

  logic [31:0]     mem [DEPTH];

  logic            accept_s;
  logic            illegal_s;
  logic            mem_we_s;
  logic            read_phase_s;
  logic            unused_s;

  // Byte lanes touched by a transfer. Lanes follow little-endian order, so
  // lane n carries bits [8n+7:8n]. Illegal sizes touch no lanes.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      3'b000:  mask = 4'b0001 << addr_lo;
      3'b001:  mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      3'b010:  mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Checks applied when a transfer is accepted. Order: size, alignment,
  // then (optionally) range.
  function automatic logic transfer_illegal(input logic [2:0] size, input logic [31:0] addr);
    logic bad;
    case (size)
      3'b000:  bad = 1'b0;
      3'b001:  bad = addr[0];
      3'b010:  bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
`ifdef AHB_SRAM_RANGE_ERR_EN
    bad = bad | (addr[31:AW+2] != {(30-AW){1'b0}});
`endif
    return bad;
  endfunction

  assign accept_s  = HSEL & HREADY & HTRANS[1];
  assign illegal_s = transfer_illegal(HSIZE, HADDR);

  // The array is written on the edge that ends a DONE write phase. A reset on
  // that same edge abandons the write.
  assign mem_we_s     = (state_r == ST_DONE) && dp_write_r && !HRESET;
  assign read_phase_s = ((state_r == ST_WAIT) || (state_r == ST_DONE)) && !dp_write_r;

  // Inputs that do not influence behaviour in every build.
  assign unused_s = ^{HBURST, HTRANS[0], HADDR[31:AW+2]};

  assign HREADYOUT = hreadyout_r;
  assign HRESP     = hresp_r;

  // Data-phase FSM: it latches the address-phase controls and drives the
  // registered ready/response outputs.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 4'd0;
      dp_index_r  <= {AW{1'b0}};
      dp_lanes_r  <= 4'b0000;
      dp_write_r  <= 1'b0;
      hreadyout_r <= 1'b1;
      hresp_r     <= RESP_OKAY;
    end else begin
      case (state_r)
        ST_WAIT: begin
          if (wait_cnt_r == 4'd0) begin
            state_r     <= ST_DONE;
            hreadyout_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end

        ST_ERR1: begin
          state_r     <= ST_ERR2;
          hreadyout_r <= 1'b1;
          hresp_r     <= RESP_ERROR;
        end

        // These states end with HREADYOUT high, so the bus can hand over the
        // next address phase.
        ST_IDLE, ST_DONE, ST_ERR2: begin
          if (accept_s) begin
            dp_index_r <= HADDR[AW+1:2];
            dp_lanes_r <= lane_mask(HSIZE, HADDR[1:0]);
            if (illegal_s) begin
              // An errored beat never touches the array.
              state_r     <= ST_ERR1;
              dp_write_r  <= 1'b0;
              hreadyout_r <= 1'b0;
              hresp_r     <= RESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state_r     <= ST_WAIT;
              wait_cnt_r  <= WS_LOAD;
              dp_write_r  <= HWRITE;
              hreadyout_r <= 1'b0;
              hresp_r     <= RESP_OKAY;
            end else begin
              state_r     <= ST_DONE;
              dp_write_r  <= HWRITE;
              hreadyout_r <= 1'b1;
              hresp_r     <= RESP_OKAY;
            end
          end else begin
            state_r     <= ST_IDLE;
            dp_write_r  <= 1'b0;
            hreadyout_r <= 1'b1;
            hresp_r     <= RESP_OKAY;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          wait_cnt_r  <= 4'd0;
          dp_write_r  <= 1'b0;
          hreadyout_r <= 1'b1;
          hresp_r     <= RESP_OKAY;
        end
      endcase
    end
  end

  // Byte-lane write into the array. The array itself is never reset.
  always_ff @(posedge HCLK) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_lanes_r[i]) begin
          mem[dp_index_r][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Read data comes straight from the array. A write that completes on the
  // edge before a read data phase is therefore already visible, and no
  // bypass path is needed.
  always_comb begin
    if (read_phase_s) begin
      HRDATA = mem[dp_index_r];
    end else begin
      HRDATA = 32'd0;
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
//
// Bench for ahb_sram_slave. It uses two instances: one with zero wait
// states and one with three. A small pipelined master drives beats from a
// queue. When a beat's address phase is accepted, the expected response is
// pushed to a scoreboard; it is popped when the data phase completes. A
// byte-lane memory model per instance provides the expected read data.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;

  localparam int DEPTH = 1024;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;
  localparam logic [2:0] SZ_B     = 3'b000;
  localparam logic [2:0] SZ_H     = 3'b001;
  localparam logic [2:0] SZ_W     = 3'b010;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_INCR4  = 3'b011;

  typedef struct packed {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic        use3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;

  logic        hsel0, hsel3;
  logic        ready0, ready3;
  logic [1:0]  resp0, resp3;
  logic [31:0] rdata0, rdata3;
  logic        obs_ready;
  logic [1:0]  obs_resp;
  logic [31:0] obs_rdata;

  beat_t addr_q[$];
  exp_t  exp_q[$];
  logic [31:0] model [2][DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign hsel0     = hsel & ~use3;
  assign hsel3     = hsel & use3;
  assign obs_ready = use3 ? ready3 : ready0;
  assign obs_resp  = use3 ? resp3  : resp0;
  assign obs_rdata = use3 ? rdata3 : rdata0;

  ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(ready0), .HREADYOUT(ready0), .HRESP(resp0), .HRDATA(rdata0)
  );

  ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HREADY(ready3), .HREADYOUT(ready3), .HRESP(resp3), .HRDATA(rdata3)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", tag, $time, obs, exp);
    end
  endtask

  task automatic add(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [2:0] bu, input logic [31:0] a, input logic [31:0] d);
    beat_t b;
    b.trans = tr; b.wr = wr; b.size = sz; b.burst = bu; b.addr = a; b.wdata = d;
    addr_q.push_back(b);
  endtask

  // Push the expected data-phase result for an accepted beat and update the model.
  task automatic accept_beat(input beat_t b);
    exp_t        e;
    logic        bad;
    logic [3:0]  m;
    logic [9:0]  idx;
    logic [31:0] w;
    bad = (b.size > 3'd2) || (b.size == SZ_H && b.addr[0]) ||
          (b.size == SZ_W && b.addr[1:0] != 2'b00);
`ifdef AHB_SRAM_RANGE_ERR_EN
    if (b.addr[31:12] != 20'd0) bad = 1'b1;
`endif
    idx     = b.addr[11:2];
    e.resp  = bad ? 2'b01 : 2'b00;
    e.waits = bad ? 32'd1 : (use3 ? 32'd3 : 32'd0);
    e.rdata = 32'd0;
    if (!bad && !b.wr) e.rdata = model[use3][idx];
    if (!bad && b.wr) begin
      case (b.size)
        SZ_B:    m = 4'b0001 << b.addr[1:0];
        SZ_H:    m = b.addr[1] ? 4'b1100 : 4'b0011;
        default: m = 4'b1111;
      endcase
      w = model[use3][idx];
      for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = b.wdata[8*i +: 8];
      model[use3][idx] = w;
    end
    exp_q.push_back(e);
  endtask

  task automatic next_addr(output beat_t cur, output bit valid);
    if (addr_q.size() > 0) begin
      cur    = addr_q.pop_front();
      valid  = 1'b1;
      hsel   = 1'b1;
      htrans = cur.trans;
      hwrite = cur.wr;
      hsize  = cur.size;
      hburst = cur.burst;
      haddr  = cur.addr;
    end else begin
      cur    = '0;
      valid  = 1'b0;
      hsel   = 1'b0;
      htrans = T_IDLE;
      hwrite = 1'b0;
      hsize  = SZ_W;
      hburst = B_SINGLE;
      haddr  = 32'd0;
    end
  endtask

  // Pipelined master: it issues the queued beats on one instance and checks every data phase.
  task automatic run_beats(input logic sel3, output int dp_cycles);
    beat_t cur;
    bit    cur_valid;
    bit    dp_busy;
    logic  rdy;
    exp_t  e;
    int    waits;
    int    budget;
    use3      = sel3;
    dp_cycles = 0;
    dp_busy   = 1'b0;
    waits     = 0;
    budget    = 0;
    @(posedge clk); #1;
    next_addr(cur, cur_valid);
    while ((dp_busy || cur_valid) && budget < 400) begin
      @(negedge clk);
      rdy = obs_ready;
      if (dp_busy) begin
        dp_cycles++;
        e = exp_q[0];
        if (rdy) begin
          check_eq("waits", 32'(waits), e.waits);
          check_eq("resp", {30'd0, obs_resp}, {30'd0, e.resp});
          check_eq("rdata", obs_rdata, e.rdata);
          void'(exp_q.pop_front());
          dp_busy = 1'b0;
        end else begin
          waits++;
          check_eq("wait_resp", {30'd0, obs_resp}, {30'd0, e.resp});
        end
      end else begin
        check_eq("idle_ready", {31'd0, rdy}, 32'd1);
      end
      @(posedge clk); #1;
      if (rdy) begin
        if (cur_valid && cur.trans[1]) begin
          accept_beat(cur);
          dp_busy = 1'b1;
          waits   = 0;
          hwdata  = cur.wr ? cur.wdata : 32'd0;
        end
        next_addr(cur, cur_valid);
      end
      budget++;
    end
    check_eq("run_done", {31'd0, (dp_busy | cur_valid)}, 32'd0);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; hsel = 1'b0; use3 = 1'b0; haddr = 32'd0; htrans = T_IDLE;
    hwrite = 1'b0; hsize = SZ_W; hburst = B_SINGLE; hwdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready0", {31'd0, ready0}, 32'd1);
    check_eq("rst_resp0",  {30'd0, resp0},  32'd0);
    check_eq("rst_rdata0", rdata0,          32'd0);
    check_eq("rst_ready3", {31'd0, ready3}, 32'd1);
    check_eq("rst_resp3",  {30'd0, resp3},  32'd0);
    check_eq("rst_rdata3", rdata3,          32'd0);

    // Zero wait states: write then an immediate read of the same word.
    add(T_NONSEQ, 1'b1, SZ_W, B_SINGLE, 32'h10, 32'hDEADBEEF);
    add(T_NONSEQ, 1'b0, SZ_W, B_SINGLE, 32'h10, 32'd0);
    // Partial-lane writes merged into one word: expected 0x1234AA00.
    add(T_NONSEQ, 1'b1, SZ_W, B_SINGLE, 32'h20, 32'h00000000);
    add(T_NONSEQ, 1'b1, SZ_B, B_SINGLE, 32'h21, 32'h0000AA00);
    add(T_NONSEQ, 1'b1, SZ_H, B_SINGLE, 32'h22, 32'h12340000);
    add(T_NONSEQ, 1'b0, SZ_W, B_SINGLE, 32'h20, 32'd0);
    // Misaligned word write is rejected, and the target word is unchanged.
    add(T_NONSEQ, 1'b1, SZ_W, B_SINGLE, 32'h04, 32'h0BADF00D);
    add(T_NONSEQ, 1'b1, SZ_W, B_SINGLE, 32'h06, 32'hFFFFFFFF);
    add(T_IDLE,   1'b0, SZ_W, B_SINGLE, 32'h00, 32'd0);
    add(T_NONSEQ, 1'b0, SZ_W, B_SINGLE, 32'h04, 32'd0);
    // Illegal size, followed immediately by a beat accepted during ERR2.
    add(T_NONSEQ, 1'b0, 3'b011, B_SINGLE, 32'h08, 32'd0);
    add(T_NONSEQ, 1'b0, SZ_W, B_SINGLE, 32'h04, 32'd0);
    // Misaligned half write, then the untouched word is read.
    add(T_NONSEQ, 1'b1, SZ_W, B_SINGLE, 32'h00, 32'h76543210);
    add(T_NONSEQ, 1'b1, SZ_H, B_SINGLE, 32'h01, 32'hFFFFFFFF);
    add(T_NONSEQ, 1'b0, SZ_W, B_SINGLE, 32'h00, 32'd0);
    // Out-of-range read: ERROR with the feature enabled, alias of 0x0 otherwise.
    add(T_NONSEQ, 1'b0, SZ_W, B_SINGLE, 32'h00001000, 32'd0);
    add(T_NONSEQ, 1'b0, SZ_B, B_SINGLE, 32'h23, 32'd0);
    run_beats(1'b0, cyc);

    // Three wait states: fill 0x40..0x4C, then read it back as an INCR4 burst.
    add(T_NONSEQ, 1'b1, SZ_W, B_INCR4, 32'h40, 32'hA0A0A0A0);
    add(T_SEQ,    1'b1, SZ_W, B_INCR4, 32'h44, 32'hB1B1B1B1);
    add(T_SEQ,    1'b1, SZ_W, B_INCR4, 32'h48, 32'hC2C2C2C2);
    add(T_SEQ,    1'b1, SZ_W, B_INCR4, 32'h4C, 32'hD3D3D3D3);
    add(T_NONSEQ, 1'b1, SZ_W, B_SINGLE, 32'h80, 32'h11111111);
    run_beats(1'b1, cyc);
    add(T_NONSEQ, 1'b0, SZ_W, B_INCR4, 32'h40, 32'd0);
    add(T_SEQ,    1'b0, SZ_W, B_INCR4, 32'h44, 32'd0);
    add(T_SEQ,    1'b0, SZ_W, B_INCR4, 32'h48, 32'd0);
    add(T_SEQ,    1'b0, SZ_W, B_INCR4, 32'h4C, 32'd0);
    run_beats(1'b1, cyc);
    check_eq("burst_cycles", 32'(cyc), 32'd16);

    // Reset in the 2nd WAIT cycle of a write: the write is abandoned.
    use3 = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = T_NONSEQ; hwrite = 1'b1; hsize = SZ_W; hburst = B_SINGLE; haddr = 32'h80;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0; hwdata = 32'hCAFEF00D;
    @(negedge clk);
    check_eq("rwait1_ready", {31'd0, ready3}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rwait2_ready", {31'd0, ready3}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_ready", {31'd0, ready3}, 32'd1);
    check_eq("mid_rst_resp",  {30'd0, resp3},  32'd0);
    check_eq("mid_rst_rdata", rdata3,          32'd0);
    add(T_NONSEQ, 1'b0, SZ_W, B_SINGLE, 32'h80, 32'd0);
    run_beats(1'b1, cyc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
